// File: rtl/hazard_stall_unit_pkg.sv
// ============================================================================
// Module   : hazard_stall_unit_pkg
// Purpose  : Shared FSM encodings, constants and the ID-source match helper
//            used by the hazard/stall controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_BUSY = 2'b01,
        IRQ     = 2'b10
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when the ID instruction sources register a; $zero never creates a dependency.
    function automatic logic reg_match(
        input logic [4:0] a,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       rt_used
    );
        return (a != REG_ZERO) && ((a == rs) || ((a == rt) && rt_used));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_unit_md_busy_timer.sv
// ============================================================================
// Module   : hazard_stall_unit_md_busy_timer
// Purpose  : Mult/div occupancy down-counter; loads MD_CYCLES-1 on issue and
//            flags the final busy cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit_md_busy_timer
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_CYCLES = 8
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_load,
    output logic o_last
);

    localparam int            c_cnt_w = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(MD_CYCLES - 1);

    logic [c_cnt_w-1:0] md_cnt_q;
    logic [c_cnt_w-1:0] md_cnt_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (i_load) begin
            md_cnt_d = c_load;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign o_last = (md_cnt_q == c_cnt_w'(1));

endmodule

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// Module   : hazard_stall_unit
// Purpose  : ID-stage hazard controller: load-use, branch-in-ID and mult/div
//            stalls, taken-branch squash and interrupt entry sequencing.
//            Optional STALL_COUNTER_EN adds stall_cnt / irq_cnt outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_CYCLES = 8,
    parameter int CNT_W     = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       intterupt,
    input  logic [4:0] rsaddr_id,
    input  logic [4:0] rtaddr_id,
    input  logic       rt_used_id,
    input  logic       branch_id,
    input  logic       taken_id,
    input  logic       MemReadEX,
    input  logic       RegWriteEX,
    input  logic [4:0] regwriteaddrEX,
    input  logic       MemReadMEM,
    input  logic [4:0] regwriteaddrMEM,
    input  logic       md_start_id,
    input  logic       hilo_rd_id,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IFIDFlush,
    output logic       IDEXFlush,
    output logic       irq_ack,
    output logic       md_busy
`ifdef STALL_COUNTER_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] irq_cnt
`endif
);

    if (MD_CYCLES < 2 || CNT_W < 1) begin : g_param_check
        $error("hazard_stall_unit: MD_CYCLES must be >= 2 and CNT_W >= 1");
    end

    state_e state_q, state_d;
    logic   irq_pend_q, irq_pend_d;
    logic   w_match_ex, w_match_mem;
    logic   w_ld_use, w_br_haz, w_md_haz, w_hazard, w_stall;
    logic   w_md_load, w_md_last;

    assign w_match_ex  = reg_match(regwriteaddrEX,  rsaddr_id, rtaddr_id, rt_used_id);
    assign w_match_mem = reg_match(regwriteaddrMEM, rsaddr_id, rtaddr_id, rt_used_id);

    assign w_ld_use = MemReadEX & w_match_ex;
    assign w_br_haz = branch_id & ((RegWriteEX & w_match_ex) | (MemReadMEM & w_match_mem));
    assign w_md_haz = (state_q == MD_BUSY) & (hilo_rd_id | md_start_id);
    assign w_hazard = w_ld_use | w_br_haz | w_md_haz;
    // The ID instruction is squashed during interrupt entry, so it cannot hold the pipe.
    assign w_stall  = w_hazard & (state_q != IRQ);

    always_comb begin
        state_d    = state_q;
        irq_pend_d = irq_pend_q | intterupt;
        w_md_load  = 1'b0;
        case (state_q)
            RUN: begin
                if (!w_stall) begin
                    if (md_start_id) begin
                        state_d   = MD_BUSY;
                        w_md_load = 1'b1;
                    end else if (irq_pend_q && !taken_id) begin
                        state_d = IRQ;
                    end
                end
            end
            MD_BUSY: begin
                if (w_md_last) begin
                    state_d = RUN;
                end
            end
            IRQ: begin
                state_d    = RUN;
                irq_pend_d = 1'b0;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RUN;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    hazard_stall_unit_md_busy_timer #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_busy_timer (
        .clk     (clk),
        .i_reset (reset),
        .i_load  (w_md_load),
        .o_last  (w_md_last)
    );

    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = taken_id;
        IDEXFlush = 1'b0;
        if (!reset) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (state_q == IRQ) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (w_stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    assign irq_ack = reset & (state_q == IRQ);
    assign md_busy = reset & (state_q == MD_BUSY);

`ifdef STALL_COUNTER_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] irq_cnt_q, irq_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(w_stall);
        irq_cnt_d   = irq_cnt_q + CNT_W'(state_q == IRQ);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            irq_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            irq_cnt_q   <= irq_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign irq_cnt   = irq_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// Module   : tb_hazard_stall_unit
// Purpose  : Directed pipeline scenarios plus randomized traffic checked
//            against a cycle-level behavioural model of the hazard unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

    localparam int MD_CYCLES = 8;
    localparam int CNT_W     = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, intterupt;
    logic [4:0] rsaddr_id, rtaddr_id, regwriteaddrEX, regwriteaddrMEM;
    logic       rt_used_id, branch_id, taken_id, MemReadEX, RegWriteEX, MemReadMEM;
    logic       md_start_id, hilo_rd_id;
    logic       PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, irq_ack, md_busy;
`ifdef STALL_COUNTER_EN
    logic [CNT_W-1:0] stall_cnt, irq_cnt;
`endif

    hazard_stall_unit #(
        .MD_CYCLES (MD_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .intterupt       (intterupt),
        .rsaddr_id       (rsaddr_id),
        .rtaddr_id       (rtaddr_id),
        .rt_used_id      (rt_used_id),
        .branch_id       (branch_id),
        .taken_id        (taken_id),
        .MemReadEX       (MemReadEX),
        .RegWriteEX      (RegWriteEX),
        .regwriteaddrEX  (regwriteaddrEX),
        .MemReadMEM      (MemReadMEM),
        .regwriteaddrMEM (regwriteaddrMEM),
        .md_start_id     (md_start_id),
        .hilo_rd_id      (hilo_rd_id),
        .PCWrite         (PCWrite),
        .IFIDWrite       (IFIDWrite),
        .IFIDFlush       (IFIDFlush),
        .IDEXFlush       (IDEXFlush),
        .irq_ack         (irq_ack),
        .md_busy         (md_busy)
`ifdef STALL_COUNTER_EN
        ,
        .stall_cnt       (stall_cnt),
        .irq_cnt         (irq_cnt)
`endif
    );

    typedef struct packed {
        logic       rst_n;
        logic       intr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rt_used;
        logic       br;
        logic       tk;
        logic       mr_ex;
        logic       rw_ex;
        logic [4:0] wa_ex;
        logic       mr_mem;
        logic [4:0] wa_mem;
        logic       md_start;
        logic       hilo;
    } stim_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: remaining mult/div busy cycles, pending request, interrupt-entry cycle.
    int          m_busy_left = 0;
    bit          m_pend      = 1'b0;
    bit          m_irq       = 1'b0;
    bit          m_known     = 1'b0;
    int unsigned m_stall_cnt = 0;
    int unsigned m_irq_cnt   = 0;

    logic o_pc, o_ifw, o_iff, o_idf, o_ack, o_busy;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic bit id_reads(input stim_t s, input logic [4:0] r);
        return (r != 5'd0) && ((r == s.rs) || (s.rt_used && (r == s.rt)));
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        reset           = s.rst_n;
        intterupt       = s.intr;
        rsaddr_id       = s.rs;
        rtaddr_id       = s.rt;
        rt_used_id      = s.rt_used;
        branch_id       = s.br;
        taken_id        = s.tk;
        MemReadEX       = s.mr_ex;
        RegWriteEX      = s.rw_ex;
        regwriteaddrEX  = s.wa_ex;
        MemReadMEM      = s.mr_mem;
        regwriteaddrMEM = s.wa_mem;
        md_start_id     = s.md_start;
        hilo_rd_id      = s.hilo;
    endtask

    // One clock: drive, compare at negedge against the model, advance the model.
    task automatic step(input stim_t s);
        bit haz, stl, pend_now;
        bit e_pc, e_ifw, e_iff, e_idf, e_ack, e_busy;
        apply(s);
        @(negedge clk);
        haz = (s.mr_ex && id_reads(s, s.wa_ex))
            || (s.br && ((s.rw_ex && id_reads(s, s.wa_ex)) || (s.mr_mem && id_reads(s, s.wa_mem))))
            || ((m_busy_left > 0) && (s.hilo || s.md_start));
        stl = haz && !m_irq;
        if (!s.rst_n) begin
            {e_pc, e_ifw, e_iff, e_idf, e_ack, e_busy} = 6'b001100;
        end else begin
            e_ack  = m_irq;
            e_busy = (m_busy_left > 0);
            if (m_irq)    {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
            else if (stl) {e_pc, e_ifw, e_iff, e_idf} = 4'b0001;
            else          {e_pc, e_ifw, e_iff, e_idf} = {2'b11, s.tk, 1'b0};
        end
        o_pc = PCWrite; o_ifw = IFIDWrite; o_iff = IFIDFlush;
        o_idf = IDEXFlush; o_ack = irq_ack; o_busy = md_busy;
        check("PCWrite",   32'(o_pc),   32'(e_pc));
        check("IFIDWrite", 32'(o_ifw),  32'(e_ifw));
        check("IFIDFlush", 32'(o_iff),  32'(e_iff));
        check("IDEXFlush", 32'(o_idf),  32'(e_idf));
        check("irq_ack",   32'(o_ack),  32'(e_ack));
        check("md_busy",   32'(o_busy), 32'(e_busy));
`ifdef STALL_COUNTER_EN
        if (m_known) begin
            check("stall_cnt", 32'(stall_cnt), m_stall_cnt % (32'd1 << CNT_W));
            check("irq_cnt",   32'(irq_cnt),   m_irq_cnt % (32'd1 << CNT_W));
        end
`endif
        if (!s.rst_n) begin
            m_busy_left = 0; m_pend = 1'b0; m_irq = 1'b0;
            m_stall_cnt = 0; m_irq_cnt = 0; m_known = 1'b1;
        end else begin
            if (stl) m_stall_cnt++;
            if (m_irq) begin
                m_irq_cnt++;
                m_irq  = 1'b0;
                m_pend = 1'b0;
            end else begin
                pend_now = m_pend;
                m_pend   = m_pend | s.intr;
                if (m_busy_left > 0)                       m_busy_left--;
                else if (!stl && s.md_start)               m_busy_left = MD_CYCLES - 1;
                else if (!stl && pend_now && !s.tk)        m_irq = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s, rs_n;
        int    cnt, acks;
        bit    seen_busy;

        rs_n = '0;
        step(rs_n);
        step(rs_n);
        check("reset_idexflush", 32'(o_idf), 32'd1);
        step(idle());
        check("run_pcwrite", 32'(o_pc), 32'd1);

        // lw $8 in EX, add $9,$8,$1 in ID
        s = idle(); s.mr_ex = 1; s.rw_ex = 1; s.wa_ex = 5'd8; s.rs = 5'd8; s.rt = 5'd1; s.rt_used = 1;
        step(s);
        check("lduse_pcwrite", 32'(o_pc), 32'd0);
        check("lduse_idexflush", 32'(o_idf), 32'd1);
        s.mr_ex = 0; s.rw_ex = 0;
        step(s);
        check("lduse_release", 32'(o_pc), 32'd1);
        // load into $0 never stalls
        s = idle(); s.mr_ex = 1; s.rw_ex = 1; s.wa_ex = 5'd0; s.rs = 5'd0; s.rt = 5'd0; s.rt_used = 1;
        step(s);
        check("lduse_zero", 32'(o_pc), 32'd1);

        // lw $8 then beq $8,$2
        cnt = 0;
        s = idle(); s.br = 1; s.rs = 5'd8; s.rt = 5'd2; s.rt_used = 1;
        s.mr_ex = 1; s.rw_ex = 1; s.wa_ex = 5'd8;
        step(s); cnt += int'(!o_pc);
        s.mr_ex = 0; s.rw_ex = 0; s.wa_ex = 0; s.mr_mem = 1; s.wa_mem = 5'd8;
        step(s); cnt += int'(!o_pc);
        s.mr_mem = 0; s.wa_mem = 0;
        step(s); cnt += int'(!o_pc);
        check("load_branch_stalls", 32'(cnt), 32'd2);

        // addu $8 then beq $8
        cnt = 0;
        s = idle(); s.br = 1; s.rs = 5'd8; s.rt = 5'd2; s.rt_used = 1; s.rw_ex = 1; s.wa_ex = 5'd8;
        step(s); cnt += int'(!o_pc);
        s.rw_ex = 0; s.wa_ex = 0; s.wa_mem = 5'd8;
        step(s); cnt += int'(!o_pc);
        check("alu_branch_stalls", 32'(cnt), 32'd1);

        // mult then mflo, with an interrupt pulse while busy
        s = idle(); s.md_start = 1;
        step(s);
        cnt = 0; seen_busy = 0; acks = 0;
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.hilo = 1; s.intr = (cnt == 2);
            step(s);
            if (o_busy) begin
                cnt++; seen_busy = 1;
                if (o_pc) check("mflo_held", 32'(o_pc), 32'd0);
            end
            acks += int'(o_ack);
            if (seen_busy && !o_busy) break;
        end
        check("md_busy_len", 32'(cnt), 32'(MD_CYCLES - 1));
        check("mflo_released", 32'(o_pc), 32'd1);
        check("irq_deferred", 32'(acks), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(idle());
            acks += int'(o_ack);
            if (o_ack) check("irq_flush", 32'({o_iff, o_idf, o_pc}), 32'b111);
        end
        check("irq_single_pulse", 32'(acks), 32'd1);

        // taken branch, no hazard
        s = idle(); s.br = 1; s.tk = 1; s.rs = 5'd3;
        step(s);
        check("taken_flush", 32'(o_iff), 32'd1);
        step(idle());
        check("taken_flush_end", 32'(o_iff), 32'd0);

        // reset in the middle of a mult/div
        s = idle(); s.md_start = 1;
        step(s);
        step(idle());
        check("md_busy_before_reset", 32'(o_busy), 32'd1);
        step(rs_n);
        step(idle());
        check("md_abort", 32'(o_busy), 32'd0);

`ifdef STALL_COUNTER_EN
        step(rs_n);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.mr_ex = 1; s.rw_ex = 1; s.wa_ex = 5'd5; s.rs = 5'd5;
            step(s);
            step(idle());
        end
        s = idle(); s.intr = 1;
        step(s);
        for (int i = 0; i < 3; i++) step(idle());
        check("stall_cnt_dir", 32'(stall_cnt), 32'd3);
        check("irq_cnt_dir", 32'(irq_cnt), 32'd1);
`endif

        step(rs_n);
        for (int i = 0; i < 3000; i++) begin
            s          = '0;
            s.rst_n    = ($urandom_range(0, 79) != 0);
            s.intr     = ($urandom_range(0, 11) == 0);
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.rt_used  = 1'($urandom_range(0, 1));
            s.br       = ($urandom_range(0, 3) == 0);
            s.tk       = s.br && ($urandom_range(0, 1) == 0);
            s.mr_ex    = ($urandom_range(0, 3) == 0);
            s.rw_ex    = s.mr_ex || ($urandom_range(0, 1) == 0);
            s.wa_ex    = 5'($urandom_range(0, 3));
            s.mr_mem   = ($urandom_range(0, 3) == 0);
            s.wa_mem   = 5'($urandom_range(0, 3));
            s.md_start = ($urandom_range(0, 7) == 0);
            s.hilo     = ($urandom_range(0, 4) == 0);
            step(s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
